multi_checker: RTL and testbench

Self-checking scoreboard for in-order transactions, up to P_DEPTH outstanding at once. Each run launch pushes its expected word into an internal FIFO. Each done completion pops the oldest expected word and compares it with data_done. Sits beside a DUT in benches and in on-chip BIST paths, and reports sticky pass/fail, error and transaction counts, first-mismatch capture, and overflow/underflow protocol faults.

---
 rtl/sync_fifo.sv | 62 ++++++
 rtl/multi_checker.sv | 116 +++++++++++
 tb/tb_multi_checker.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo.sv
// Register-array FIFO with show-ahead head and registered occupancy flags.
// Simultaneous read and write is legal when full.
module sync_fifo #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [P_DATA_WIDTH-1:0]    wr_data,
  input  logic                       rd_en,
  output logic [P_DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(P_DEPTH):0]   level,
  output logic                       empty,
  output logic                       full
);
  localparam int LP_PTR_W = $clog2(P_DEPTH);
  localparam int LP_LVL_W = LP_PTR_W + 1;

  logic [P_DATA_WIDTH-1:0] r_mem [P_DEPTH];
  logic [LP_PTR_W-1:0]     r_wr_ptr;
  logic [LP_PTR_W-1:0]     r_rd_ptr;
  logic [LP_LVL_W-1:0]     r_level;
  logic                    r_empty;
  logic                    r_full;
  logic [LP_LVL_W-1:0]     w_level_nxt;

  always_comb begin
    w_level_nxt = r_level;
    case ({wr_en, rd_en})
      2'b10:   w_level_nxt = r_level + LP_LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LP_LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Flags follow the next-state level so they stay aligned with level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + LP_PTR_W'(1);
      if (rd_en) r_rd_ptr <= r_rd_ptr + LP_PTR_W'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == LP_LVL_W'(0));
      r_full  <= (w_level_nxt == LP_LVL_W'(P_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;
  assign empty   = r_empty;
  assign full    = r_full;
endmodule

// File: rtl/multi_checker.sv
// In-order scoreboard: runs queue expected words, dones compare against the oldest.
// Reports sticky status, saturating counters and first-mismatch capture.
module multi_checker #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_DEPTH      = 4,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [P_DATA_WIDTH-1:0]   data_run,
  input  logic                      run,
  input  logic [P_DATA_WIDTH-1:0]   data_done,
  input  logic                      done,
  output logic                      busy,
  output logic                      full,
  output logic [$clog2(P_DEPTH):0]  level,
  output logic                      ran,
  output logic                      ok,
  output logic                      ovf,
  output logic                      unf,
  output logic [P_CNT_WIDTH-1:0]    run_cnt,
  output logic [P_CNT_WIDTH-1:0]    done_cnt,
  output logic [P_CNT_WIDTH-1:0]    err_cnt,
  output logic [P_DATA_WIDTH-1:0]   first_exp,
  output logic [P_DATA_WIDTH-1:0]   first_got,
  output logic [P_CNT_WIDTH-1:0]    first_idx
);
  localparam logic [P_CNT_WIDTH-1:0] LP_CNT_MAX = '1;

  logic [P_DATA_WIDTH-1:0] w_head;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_unf;
  logic                    w_mismatch;

  logic                    r_ran, r_ok, r_ovf, r_unf;
  logic [P_CNT_WIDTH-1:0]  r_run_cnt, r_done_cnt, r_err_cnt, r_first_idx;
  logic [P_DATA_WIDTH-1:0] r_first_exp, r_first_got;

  // A pop frees a slot in the same cycle, so a run at full is still accepted.
  assign w_pop      = done & ~w_empty;
  assign w_push     = run & (~w_full | w_pop);
  assign w_drop     = run & w_full & ~w_pop;
  assign w_unf      = done & w_empty;
  assign w_mismatch = w_pop & (w_head != data_done);

  sync_fifo #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_DEPTH      (P_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (data_run),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .level   (level),
    .empty   (w_empty),
    .full    (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ran       <= 1'b0;
      r_ok        <= 1'b1;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_run_cnt   <= '0;
      r_done_cnt  <= '0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else begin
      if (w_push) begin
        r_ran <= 1'b1;
        if (r_run_cnt != LP_CNT_MAX) r_run_cnt <= r_run_cnt + P_CNT_WIDTH'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        r_ok  <= 1'b0;
      end
      if (w_unf) begin
        r_unf <= 1'b1;
        r_ok  <= 1'b0;
      end
      if (w_pop && r_done_cnt != LP_CNT_MAX) r_done_cnt <= r_done_cnt + P_CNT_WIDTH'(1);
      // Capture keys off err_cnt==0, so a saturated err_cnt never re-arms it.
      if (w_mismatch) begin
        r_ok <= 1'b0;
        if (r_err_cnt != LP_CNT_MAX) r_err_cnt <= r_err_cnt + P_CNT_WIDTH'(1);
        if (r_err_cnt == '0) begin
          r_first_exp <= w_head;
          r_first_got <= data_done;
          r_first_idx <= r_done_cnt;
        end
      end
    end
  end

  assign busy      = ~w_empty;
  assign full      = w_full;
  assign ran       = r_ran;
  assign ok        = r_ok;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign run_cnt   = r_run_cnt;
  assign done_cnt  = r_done_cnt;
  assign err_cnt   = r_err_cnt;
  assign first_exp = r_first_exp;
  assign first_got = r_first_got;
  assign first_idx = r_first_idx;
endmodule

// File: tb/tb_multi_checker.sv
// Directed bench for multi_checker: stimulus queues expected values, a negedge monitor compares.
module tb_multi_checker;
  localparam int DW = 32;
  localparam int DP = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_run = '0;
  logic          run = 1'b0;
  logic [DW-1:0] data_done = '0;
  logic          done = 1'b0;
  logic          busy, full, ran, ok, ovf, unf;
  logic [2:0]    level;
  logic [CW-1:0] run_cnt, done_cnt, err_cnt, first_idx;
  logic [DW-1:0] first_exp, first_got;

  multi_checker #(.P_DATA_WIDTH(DW), .P_DEPTH(DP), .P_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .data_run(data_run), .run(run),
    .data_done(data_done), .done(done), .busy(busy), .full(full),
    .level(level), .ran(ran), .ok(ok), .ovf(ovf), .unf(unf),
    .run_cnt(run_cnt), .done_cnt(done_cnt), .err_cnt(err_cnt),
    .first_exp(first_exp), .first_got(first_got), .first_idx(first_idx)
  );

  always #5 clk = ~clk;

  localparam int S_BUSY = 0, S_FULL = 1, S_LEVEL = 2, S_RAN = 3, S_OK = 4,
                 S_OVF = 5, S_UNF = 6, S_RCNT = 7, S_DCNT = 8, S_ECNT = 9,
                 S_FEXP = 10, S_FGOT = 11, S_FIDX = 12;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] get_act(int sel);
    case (sel)
      S_BUSY:  return 32'(busy);
      S_FULL:  return 32'(full);
      S_LEVEL: return 32'(level);
      S_RAN:   return 32'(ran);
      S_OK:    return 32'(ok);
      S_OVF:   return 32'(ovf);
      S_UNF:   return 32'(unf);
      S_RCNT:  return 32'(run_cnt);
      S_DCNT:  return 32'(done_cnt);
      S_ECNT:  return 32'(err_cnt);
      S_FEXP:  return first_exp;
      S_FGOT:  return first_got;
      S_FIDX:  return 32'(first_idx);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: outputs are stable at negedge; drain every expectation queued since.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = get_act(e.sel);
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", e.name, act, e.val, $time);
      end
    end
  end

  task automatic ex(int sel, logic [31:0] v, string n);
    exp_t e;
    e.sel = sel; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  // One clock: drive at negedge, let the edge happen, then hold quiet.
  task automatic step(logic r, logic rv, logic [DW-1:0] dr, logic dv, logic [DW-1:0] dd);
    @(negedge clk);
    rst = r; run = rv; data_run = dr; done = dv; data_done = dd;
    @(posedge clk);
    #1;
    rst = 1'b0; run = 1'b0; done = 1'b0;
  endtask

  task automatic chk_reset(string tag);
    ex(S_BUSY, 0, {tag, ".busy"});   ex(S_FULL, 0, {tag, ".full"});
    ex(S_LEVEL, 0, {tag, ".level"}); ex(S_RAN, 0, {tag, ".ran"});
    ex(S_OK, 1, {tag, ".ok"});       ex(S_OVF, 0, {tag, ".ovf"});
    ex(S_UNF, 0, {tag, ".unf"});     ex(S_RCNT, 0, {tag, ".run_cnt"});
    ex(S_DCNT, 0, {tag, ".done_cnt"}); ex(S_ECNT, 0, {tag, ".err_cnt"});
    ex(S_FEXP, 0, {tag, ".first_exp"}); ex(S_FGOT, 0, {tag, ".first_got"});
    ex(S_FIDX, 0, {tag, ".first_idx"});
  endtask

  initial begin
    // T1: three in-order matching transactions
    step(1, 0, 0, 0, 0);
    chk_reset("t1_rst");
    step(0, 1, 32'hA, 0, 0);
    ex(S_RAN, 1, "t1_ran"); ex(S_BUSY, 1, "t1_busy");
    step(0, 1, 32'hB, 0, 0);
    step(0, 1, 32'hC, 0, 0);
    ex(S_LEVEL, 3, "t1_peak"); ex(S_FULL, 0, "t1_notfull");
    step(0, 0, 0, 1, 32'hA);
    step(0, 0, 0, 1, 32'hB);
    ex(S_LEVEL, 1, "t1_lvl1");
    step(0, 0, 0, 1, 32'hC);
    ex(S_LEVEL, 0, "t1_lvl0"); ex(S_BUSY, 0, "t1_idle"); ex(S_OK, 1, "t1_ok");
    ex(S_RCNT, 3, "t1_rcnt"); ex(S_DCNT, 3, "t1_dcnt"); ex(S_ECNT, 0, "t1_ecnt");

    // T2: two mismatches, only the first is captured
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h1, 0, 0);
    step(0, 1, 32'h2, 0, 0);
    step(0, 1, 32'h3, 0, 0);
    step(0, 0, 0, 1, 32'h1);
    ex(S_OK, 1, "t2_ok_before");
    step(0, 0, 0, 1, 32'h5);
    step(0, 0, 0, 1, 32'h7);
    ex(S_ECNT, 2, "t2_ecnt"); ex(S_OK, 0, "t2_ok"); ex(S_FEXP, 32'h2, "t2_fexp");
    ex(S_FGOT, 32'h5, "t2_fgot"); ex(S_FIDX, 1, "t2_fidx"); ex(S_DCNT, 3, "t2_dcnt");

    // T3: overflow, then run+done at full
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, DW'(i), 0, 0);
    ex(S_FULL, 1, "t3_full"); ex(S_LEVEL, 4, "t3_lvl4"); ex(S_OVF, 0, "t3_noovf");
    step(0, 1, 32'h5, 0, 0);
    ex(S_OVF, 1, "t3_ovf"); ex(S_OK, 0, "t3_ok"); ex(S_RCNT, 4, "t3_rcnt4");
    step(0, 1, 32'h9, 1, 32'h1);
    ex(S_LEVEL, 4, "t3_lvl_hold"); ex(S_FULL, 1, "t3_full_hold");
    ex(S_RCNT, 5, "t3_rcnt5"); ex(S_DCNT, 1, "t3_dcnt1"); ex(S_ECNT, 0, "t3_ecnt0");
    step(0, 0, 0, 1, 32'h2);
    step(0, 0, 0, 1, 32'h3);
    step(0, 0, 0, 1, 32'h4);
    step(0, 0, 0, 1, 32'h9);
    ex(S_ECNT, 0, "t3_drain_ecnt"); ex(S_LEVEL, 0, "t3_drain_lvl"); ex(S_DCNT, 5, "t3_dcnt5");

    // T4: done on empty FIFO with a same-cycle run
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h3, 1, 32'h3);
    ex(S_UNF, 1, "t4_unf"); ex(S_OK, 0, "t4_ok"); ex(S_DCNT, 0, "t4_dcnt0");
    ex(S_LEVEL, 1, "t4_lvl1"); ex(S_RCNT, 1, "t4_rcnt1");
    step(0, 0, 0, 1, 32'h3);
    ex(S_ECNT, 0, "t4_ecnt"); ex(S_DCNT, 1, "t4_dcnt1"); ex(S_LEVEL, 0, "t4_lvl0");

    // T5: reset mid-operation discards outstanding entries
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h5, 0, 0);
    step(0, 1, 32'h6, 0, 0);
    ex(S_LEVEL, 2, "t5_lvl2");
    step(1, 0, 0, 0, 0);
    chk_reset("t5_rst");
    step(0, 0, 0, 1, 32'h5);
    ex(S_UNF, 1, "t5_unf"); ex(S_DCNT, 0, "t5_dcnt0");

    // T6: 20 pipelined pairs saturate 4-bit counters and wrap pointers
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h100, 0, 0);
    for (int i = 1; i < 20; i++) step(0, 1, DW'(32'h100 + i), 1, DW'(32'h100 + i - 1));
    step(0, 0, 0, 1, DW'(32'h100 + 19));
    ex(S_RCNT, 15, "t6_rcnt"); ex(S_DCNT, 15, "t6_dcnt"); ex(S_OK, 1, "t6_ok");
    ex(S_ECNT, 0, "t6_ecnt"); ex(S_LEVEL, 0, "t6_lvl0"); ex(S_UNF, 0, "t6_unf");

    begin
      int budget = 20;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (q.size() > 0) begin
        failures++;
        $display("FAIL drain pending=%0d exp=0", q.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
